// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - single-outstanding Wishbone classic-cycle initiator
// Optional bus timeout abort is built when WB_INITIATOR_TIMEOUT_EN is defined.
module wb_initiator #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_dat_i,
  input  logic [3:0]        req_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [3:0]        sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  // Marker block only: flags an out-of-range TIMEOUT in the elaborated hierarchy.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_out_of_range
  end
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          adr_d   = req_addr_i;
          wdat_d  = req_dat_i;
          sel_d   = req_sel_i;
          cyc_d   = 1'b1;
          state_d = BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        // An ack on the final timeout edge still completes normally.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wb_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef WB_INITIATOR_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Ready is forced low while reset is asserted, not just after the first edge.
  assign req_ready_o = (state_q == IDLE) && !wb_rst_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = wdat_q;
  assign wb_sel_o    = sel_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - self-checking bench for wb_initiator
// Responder: 4-pin GPIO (out in byte0, oe in byte3, pin1 pulled high), programmable ack delay.
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  always #5 clk = ~clk;

  wb_initiator #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack)
  );

  // Responder model
  logic [3:0] gp_out, gp_oe;
  int         ack_delay = 2;
  int         ack_cnt;
  assign wb_ack   = wb_stb && (ack_delay > 0) && (ack_cnt == ack_delay - 1);
  assign wb_dat_i = {16'h0, 4'h0, gp_oe, 4'h0, gp_out};
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gp_out  <= 4'h0;
      gp_oe   <= 4'h0;
      ack_cnt <= 0;
    end else begin
      ack_cnt <= (wb_stb && !wb_ack) ? ack_cnt + 1 : 0;
      if (wb_stb && wb_ack && wb_we) begin
        if (wb_sel[0]) gp_out <= wb_dat_o[3:0];
        if (wb_sel[3]) gp_oe  <= wb_dat_o[27:24];
      end
    end
  end
  wire [3:0] gp_pins = (gp_out & gp_oe) | (4'b0010 & ~gp_oe);

  // Bus monitor: strobe cycles, bus-field stability, accept times
  logic [31:0] exp_adr, exp_wdat;
  logic [3:0]  exp_sel;
  logic        exp_we;
  int          stb_cycles = 0;
  int          bus_bad = 0;
  int          cyc_no = 0;
  int          acc_q[$];
  always @(posedge clk) begin
    cyc_no <= cyc_no + 1;
    if (req_valid && req_ready) acc_q.push_back(cyc_no);
    if (wb_stb) begin
      stb_cycles <= stb_cycles + 1;
      if (wb_cyc !== 1'b1 || wb_adr !== exp_adr || wb_sel !== exp_sel ||
          wb_we !== exp_we || (exp_we && wb_dat_o !== exp_wdat))
        bus_bad <= bus_bad + 1;
    end
  end

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          stb;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] edat;
  } vec_t;
  vec_t vecs[8];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [3:0] sel, input logic [31:0] edat, input logic eerr,
                         input int estb, input int hold, input int budget, input string name);
    exp_t e;
    int   base, bad0;
    bit   ok;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_dat = wdat; req_sel = sel;
    rsp_ready = 1'b0;
    exp_we = we; exp_adr = addr; exp_wdat = wdat; exp_sel = sel;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s accept: req_ready never high within 20 cycles", name);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    base = stb_cycles; bad0 = bus_bad;
    e.dat = edat; e.err = eerr; e.stb = estb;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s rsp: rsp_valid never high within %0d cycles", name, budget);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk({name, " rsp_dat"}, rsp_dat, e.dat);
    chk({name, " rsp_err"}, {31'h0, rsp_err}, {31'h0, e.err});
    chk({name, " stb_cycles"}, stb_cycles - base, e.stb);
    chk({name, " bus_stable"}, bus_bad - bad0, 0);
    chk({name, " stb_low"}, {31'h0, wb_stb}, 32'h0);
    if (hold > 0) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_dat = 32'h0; req_sel = 4'hF;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({name, " hold rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({name, " hold rsp_dat"}, rsp_dat, e.dat);
        chk({name, " hold req_ready"}, {31'h0, req_ready}, 32'h0);
        chk({name, " hold stb"}, {31'h0, wb_stb}, 32'h0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({name, " rsp_valid cleared"}, {31'h0, rsp_valid}, 32'h0);
    chk({name, " ready after consume"}, {31'h0, req_ready}, 32'h1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0000, 32'h0100_0001, 4'b1111, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0,         4'b1111, 32'h0000_0101};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h0F00_000A, 4'b0001, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'h0000_010A};
    vecs[4] = '{1'b1, 32'h0000_0020, 32'h0F00_0005, 4'b1000, 32'h0000_0000};
    vecs[5] = '{1'b0, 32'h0000_0024, 32'h0,         4'b0011, 32'h0000_0F0A};
    vecs[6] = '{1'b1, 32'h0000_0030, 32'hFFFF_FFF3, 4'b0110, 32'h0000_0000};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'b1111, 32'h0000_0F0A};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_dat = '0;
    req_sel = '0; rsp_ready = 1'b0; exp_we = 1'b0; exp_adr = '0; exp_wdat = '0; exp_sel = '0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", {31'h0, req_ready}, 32'h0);
    chk("reset cyc_stb", {30'h0, wb_cyc, wb_stb}, 32'h0);
    chk("reset rsp", {rsp_dat[30:0] , rsp_valid} | {31'h0, rsp_err}, 32'h0);
    chk("reset wb fields", wb_adr | wb_dat_o | {27'h0, wb_sel, wb_we}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdat, vecs[i].sel, vecs[i].edat, 1'b0, 2,
              (i == 1) ? 5 : 0, 20, $sformatf("vec%0d", i));
      if (i == 0) chk("gpio pins", {28'h0, gp_pins}, 32'h3);
    end

    // Back-to-back throughput with registered ack and rsp_ready tied high
    @(negedge clk);
    begin
      int n0;
      n0 = acc_q.size();
      exp_we = 1'b0; exp_adr = 32'h8; exp_sel = 4'hF;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_sel = 4'hF; rsp_ready = 1'b1;
      repeat (14) @(negedge clk);
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      rsp_ready = 1'b0;
      chk("b2b accept count", acc_q.size() - n0, 4);
      if (acc_q.size() >= n0 + 4)
        for (int k = 1; k < 4; k++)
          chk($sformatf("b2b spacing%0d", k), acc_q[n0 + k] - acc_q[n0 + k - 1], 4);
    end

    // Asynchronous reset in the middle of a bus cycle
    ack_delay = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; req_sel = 4'hF;
    exp_we = 1'b0; exp_adr = 32'h4; exp_sel = 4'hF;
    chk("rst-mid ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst-mid stb before", {31'h0, wb_stb}, 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst-mid cyc_stb", {30'h0, wb_cyc, wb_stb}, 32'h0);
    chk("rst-mid rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst-mid req_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 2;
    run_req(1'b1, 32'h0, 32'h0100_0005, 4'hF, 32'h0, 1'b0, 2, 0, 20, "after-rst write");
    run_req(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_0105, 1'b0, 2, 0, 20, "after-rst read");

`ifdef WB_INITIATOR_TIMEOUT_EN
    ack_delay = 0;
    run_req(1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b1, 4, 0, 20, "timeout abort");
    ack_delay = 4;
    run_req(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_0105, 1'b0, 4, 0, 20, "ack on last edge");
    ack_delay = 2;
`else
    ack_delay = 300;
    run_req(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_0105, 1'b0, 300, 0, 400, "long ack");
    ack_delay = 2;
`endif

    chk("scoreboard empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
